// File: rtl/nand_flash_responder_if.sv
// Memory command interface between the NAND flash controller (master) and
// the memory-side responder (slave): command, program-data and read-data streams.
interface nand_flash_responder_if #(
    parameter int AddressWidth = 16,
    parameter int CommandWidth = 3,
    parameter int DataWidth    = 8
);
    logic                    cmd_valid;
    logic [CommandWidth-1:0] cmd;
    logic [AddressWidth-1:0] addr;
    logic                    cmd_ready;
    logic                    wr_valid;
    logic [DataWidth-1:0]    wr_data;
    logic                    wr_ready;
    logic                    rd_valid;
    logic [DataWidth-1:0]    rd_data;
    logic                    rd_ready;
    logic                    busy_n;
    logic                    done;
    logic                    fail;

    modport master (
        output cmd_valid, cmd, addr, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy_n, done, fail
    );

    modport slave (
        input  cmd_valid, cmd, addr, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy_n, done, fail
    );
endinterface

// File: rtl/nand_flash_responder.sv
// Memory-side NAND model: erase/program/read on a small page array with
// bit-clearing program semantics and fixed busy latencies.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | cmd_ready high; done/fail pulse here after an operation
// ERASE_BUSY | busy_n low; block set to all-ones on the last cycle
// PROG_LOAD  | wr_ready high; collecting PageSize beats into the buffer
// PROG_BUSY  | busy_n low; page ANDed with the buffer on the last cycle
// READ_BUSY  | busy_n low; array access latency before streaming
// READ_OUT   | rd_valid high; one beat per rd_valid && rd_ready
module nand_flash_responder #(
    parameter int AddressWidth   = 16,
    parameter int CommandWidth   = 3,
    parameter int DataWidth      = 8,
    parameter int PageSize       = 16,
    parameter int NumPages       = 16,
    parameter int PagesPerBlock  = 4,
    parameter int EraseLatency   = 8,
    parameter int ProgramLatency = 4,
    parameter int ReadLatency    = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    nand_flash_responder_if.slave bus
);
    localparam int PageBits = $clog2(NumPages);
    localparam int BeatBits = $clog2(PageSize);
    localparam int LatMax   = (EraseLatency > ProgramLatency)
                              ? ((EraseLatency > ReadLatency) ? EraseLatency : ReadLatency)
                              : ((ProgramLatency > ReadLatency) ? ProgramLatency : ReadLatency);
    localparam int CntWidth = $clog2(LatMax + 1);

    localparam logic [CommandWidth-1:0] CmdErase   = CommandWidth'(0);
    localparam logic [CommandWidth-1:0] CmdProgram = CommandWidth'(1);
    localparam logic [CommandWidth-1:0] CmdRead    = CommandWidth'(2);
    localparam logic [PageBits-1:0]     BlockMask  = ~PageBits'(PagesPerBlock - 1);
    localparam logic [BeatBits-1:0]     LastBeat   = BeatBits'(PageSize - 1);

    typedef enum logic [2:0] {
        IDLE, ERASE_BUSY, PROG_LOAD, PROG_BUSY, READ_BUSY, READ_OUT
    } state_t;

    state_t                state_q;
    logic [PageBits-1:0]   page_q;
    logic [BeatBits-1:0]   beat_q;
    logic [CntWidth-1:0]   lat_q;
    logic                  cmd_ready_q;
    logic                  wr_ready_q;
    logic                  rd_valid_q;
    logic [DataWidth-1:0]  rd_data_q;
    logic                  busy_n_q;
    logic                  done_q;
    logic                  fail_q;

    // Array and page buffer are deliberately not reset.
    logic [DataWidth-1:0]  mem_q      [NumPages*PageSize];
    logic [DataWidth-1:0]  page_buf_q [PageSize];

    logic                  erase_commit;
    logic                  prog_commit;
    logic [PageBits-1:0]   blk_base;
    logic [BeatBits-1:0]   rd_beat_d;
    logic [DataWidth-1:0]  rd_word;
    logic                  unused_addr_bits;

    assign erase_commit     = (state_q == ERASE_BUSY) && (lat_q == '0);
    assign prog_commit      = (state_q == PROG_BUSY) && (lat_q == '0);
    assign blk_base         = page_q & BlockMask;
    assign rd_beat_d        = (state_q == READ_OUT) ? beat_q + 1'b1 : '0;
    assign rd_word          = mem_q[{page_q, rd_beat_d}];
    assign unused_addr_bits = ^bus.addr[AddressWidth-1:PageBits];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            page_q      <= '0;
            beat_q      <= '0;
            lat_q       <= '0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            busy_n_q    <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        page_q <= bus.addr[PageBits-1:0];
                        beat_q <= '0;
                        case (bus.cmd)
                            CmdErase: begin
                                state_q     <= ERASE_BUSY;
                                lat_q       <= CntWidth'(EraseLatency - 1);
                                cmd_ready_q <= 1'b0;
                                busy_n_q    <= 1'b0;
                            end
                            CmdProgram: begin
                                state_q     <= PROG_LOAD;
                                cmd_ready_q <= 1'b0;
                                wr_ready_q  <= 1'b1;
                            end
                            CmdRead: begin
                                state_q     <= READ_BUSY;
                                lat_q       <= CntWidth'(ReadLatency - 1);
                                cmd_ready_q <= 1'b0;
                                busy_n_q    <= 1'b0;
                            end
                            default: fail_q <= 1'b1;
                        endcase
                    end
                end
                ERASE_BUSY, PROG_BUSY: begin
                    if (lat_q == '0) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_n_q    <= 1'b1;
                        done_q      <= 1'b1;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                PROG_LOAD: begin
                    if (bus.wr_valid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == LastBeat) begin
                            state_q    <= PROG_BUSY;
                            lat_q      <= CntWidth'(ProgramLatency - 1);
                            wr_ready_q <= 1'b0;
                            busy_n_q   <= 1'b0;
                        end
                    end
                end
                READ_BUSY: begin
                    if (lat_q == '0) begin
                        state_q    <= READ_OUT;
                        beat_q     <= '0;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= rd_word;
                        busy_n_q   <= 1'b1;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                READ_OUT: begin
                    if (bus.rd_ready) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == LastBeat) begin
                            state_q     <= IDLE;
                            rd_valid_q  <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            rd_data_q <= rd_word;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    wr_ready_q  <= 1'b0;
                    rd_valid_q  <= 1'b0;
                    busy_n_q    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == PROG_LOAD) && bus.wr_valid) begin
            page_buf_q[beat_q] <= bus.wr_data;
        end
    end

    // NAND program can only clear bits, so the commit is old & buffer.
    always_ff @(posedge clk) begin
        if (erase_commit) begin
            for (int p = 0; p < PagesPerBlock; p++) begin
                for (int b = 0; b < PageSize; b++) begin
                    mem_q[{blk_base | PageBits'(p), BeatBits'(b)}] <= '1;
                end
            end
        end else if (prog_commit) begin
            for (int b = 0; b < PageSize; b++) begin
                mem_q[{page_q, BeatBits'(b)}] <= mem_q[{page_q, BeatBits'(b)}] & page_buf_q[b];
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.busy_n    = busy_n_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
endmodule

// File: doc/nand_flash_responder.md
# nand_flash_responder

Memory-side responder for the NAND flash controller's memory command interface. Accepts `mem_erase`, `mem_program_page` and `mem_page_read` commands with a page/block address, models a small NAND array with NAND bit semantics and fixed busy latencies, and exchanges page data over valid/ready streams. It is the memory end that the controller state machine drives: it supplies the ready/busy, data and completion signals that the controller's wait states poll.

## Interface
- AddressWidth, 16, width of `addr`.
- CommandWidth, 3, width of `cmd`. Encodings: 0 = erase, 1 = program page, 2 = page read, 3..7 = illegal.
- DataWidth, 8, page data beat width.
- PageSize, 16, beats per page; power of 2, at least 2.
- NumPages, 16, pages in the array; power of 2.
- PagesPerBlock, 4, pages per erase block; power of 2, divides NumPages.
- EraseLatency / ProgramLatency / ReadLatency, 8 / 4 / 2, busy cycles per operation; each at least 1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd  in  CommandWidth  operation code.
- addr  in  AddressWidth  page address; `page = addr[log2(NumPages)-1:0]`, upper bits ignored.
- cmd_ready  out  1  high only in IDLE.
- wr_valid  in  1  program data beat valid.
- wr_data  in  DataWidth  program data.
- wr_ready  out  1  high only in PROG_LOAD.
- rd_valid  out  1  read data beat valid.
- rd_data  out  DataWidth  read data.
- rd_ready  in  1  consumer accepts the read beat.
- busy_n  out  1  ready/busy; 0 while an array operation is in progress.
- done  out  1  one-cycle pulse when an operation completes.
- fail  out  1  one-cycle pulse when an illegal command is received.

## Operation
- States: IDLE, ERASE_BUSY, PROG_LOAD, PROG_BUSY, READ_BUSY, READ_OUT.
- A command is accepted when `cmd_valid && cmd_ready`. The responder latches `cmd` and the page on that edge.
- **Erase** (IDLE→ERASE_BUSY): runs for EraseLatency cycles. On the last cycle, every page in block `page/PagesPerBlock` is set to all-ones (`{DataWidth{1'b1}}`). Then →IDLE with `done`.
- **Program** (IDLE→PROG_LOAD):
  - Accepts exactly PageSize beats, one per `wr_valid && wr_ready`, into an internal page buffer, beat index 0 upward.
  - After the last beat →PROG_BUSY for ProgramLatency cycles. On the last cycle, the array page is written as `old & buffer` (NAND can only clear bits). Then →IDLE with `done`.
- **Read** (IDLE→READ_BUSY): runs for ReadLatency cycles, then →READ_OUT.
  - READ_OUT presents beat 0..PageSize-1 on `rd_data` with `rd_valid = 1`.
  - A beat advances only on `rd_valid && rd_ready`. `rd_data` is held stable while stalled.
  - After the last accepted beat →IDLE with `done`.
- **Illegal cmd** (3..7): accepted, `fail` pulses the next cycle, state stays IDLE, array unchanged.
- `cmd_valid` outside IDLE is ignored (not accepted). `wr_valid` outside PROG_LOAD is ignored.
- Array contents are not reset and are undefined after power-up; they retain committed values across `rst_n`.

## Timing
- Reset values: state IDLE; `cmd_ready` = 1, `wr_ready` = 0, `rd_valid` = 0, `rd_data` = 0, `busy_n` = 1, `done` = 0, `fail` = 0; beat and latency counters = 0; page buffer contents don't-care.
- **Command accept**: a command accepted at edge T changes state at T. `cmd_ready` is 0 from the cycle after T.
- **busy_n**: low for exactly the latency count of cycles, beginning the cycle after acceptance (erase, read) or after the last program beat. It is high in PROG_LOAD and READ_OUT.
- **done / fail**: each is high for exactly one cycle, the first cycle back in IDLE, coinciding with `cmd_ready` = 1. A new command may be accepted in that same cycle.
- **Read latency**: first `rd_valid` appears at cycle acceptance + ReadLatency + 1. With `rd_ready` held high, beats are back-to-back, one per cycle.
- **Program commit**: the array write takes effect on the final PROG_BUSY edge. A read issued in the `done` cycle returns the new data.
- **Reset mid-operation**: returns to IDLE immediately.
  - Any uncommitted erase or program is discarded and the array is unchanged.
  - A partial read stream is truncated.
  - No `done` is issued.
- Beat counter wraps at PageSize. Page index arithmetic is modulo NumPages.

## Test plan
- **Erase then read**: erase page 5 (block 1) → `busy_n` low 8 cycles, `done` once. Read page 4 → 16 beats of 8'hFF, first `rd_valid` 3 cycles after accept.
- **Program then read**: after erase, program page 6 with beats 8'h00..8'h0F → `done` after 4 busy cycles. Read page 6 returns 8'h00..8'h0F in order.
- **Bit-AND semantics**: erase, program page 2 with all 8'hF0, program again with all 8'h3C → read returns all 8'h30.
- **Backpressure and illegal cmd**: read with `rd_ready` toggling every other cycle → `rd_data` stable while stalled, 16 beats total, no loss or duplication. Then `cmd` = 5 → `fail` for 1 cycle, no `busy_n` drop, array unchanged.
- **Reset mid-operation**: assert `rst_n` = 0 during PROG_BUSY of a page-3 program over 8'hFF data → all outputs at reset values; a subsequent read of page 3 returns all 8'hFF and no `done` from the aborted operation.
- **Address masking and ignored inputs**: `addr` = 16'h0013 targets page 3. `cmd_valid` held high during READ_OUT is not accepted until the `done` cycle.
